// File: rtl/lcd_line_fetch.sv
// Ping-pong line buffer feeding the LCD controller from frame memory.
// Optional test-pattern read path is compiled in with LCD_TESTPAT_EN.
module lcd_line_fetch #(
    parameter int HPXL  = 800,
    parameter int VPXL  = 480,
    parameter int BURST = 16,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          iRD_EN,
    input  logic [9:0]    iHADDR,
    input  logic [8:0]    iVADDR,
    output logic [23:0]   oCOLOR,
    input  logic [AW-1:0] iFRAME_BASE,
    output logic          oMEM_REQ,
    output logic [AW-1:0] oMEM_ADDR,
    input  logic          iMEM_ACK,
    input  logic          iMEM_VALID,
    input  logic [23:0]   iMEM_DATA,
    output logic          oUNDERRUN,
    output logic          oBUSY,
    input  logic          iTESTPAT
);

    localparam int HW = $clog2(HPXL);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [HW-1:0] COL_LAST  = HW'(HPXL - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
    localparam logic [8:0]    LAST_V    = 9'(VPXL - 1);
    localparam logic [9:0]    HPXL_H    = 10'(HPXL);
    localparam logic [AW-1:0] HPXL_A    = AW'(HPXL);
    localparam logic [AW-1:0] BURST_A   = AW'(BURST);

    logic [1:0]    state;
    logic          pend;
    logic          primed;
    logic [8:0]    nxt_line;
    logic [8:0]    cur_v;
    logic          fbank;
    logic [HW-1:0] col;
    logic [BW-1:0] beat;
    logic [AW-1:0] base;
    logic [1:0]    valid;
    logic [8:0]    tag [2];

    logic [23:0]   buf_ram [2][HPXL];

    logic [AW-1:0] fetch_base;
    logic [AW-1:0] line_off;
    logic [8:0]    v_next;
    logic          rb;
    logic          tp_on;

    // Base is re-sampled only at the top of a frame so one frame never mixes bases.
    assign fetch_base = (nxt_line == 9'd0) ? iFRAME_BASE : base;
    assign line_off   = AW'(nxt_line) * HPXL_A;
    assign v_next     = (iVADDR == LAST_V) ? 9'd0 : iVADDR + 9'd1;
    assign rb         = iVADDR[0];

`ifdef LCD_TESTPAT_EN
    assign tp_on = iTESTPAT;
`else
    logic unused_testpat;
    assign unused_testpat = iTESTPAT;
    assign tp_on = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= S_IDLE;
            pend      <= 1'b1;
            primed    <= 1'b0;
            nxt_line  <= '0;
            cur_v     <= '0;
            fbank     <= 1'b0;
            col       <= '0;
            beat      <= '0;
            base      <= '0;
            oMEM_REQ  <= 1'b0;
            oMEM_ADDR <= '0;
            oBUSY     <= 1'b0;
            valid     <= 2'b00;
            tag[0]    <= '0;
            tag[1]    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pend) begin
                        pend             <= 1'b0;
                        fbank            <= nxt_line[0];
                        valid[nxt_line[0]] <= 1'b0;
                        tag[nxt_line[0]] <= nxt_line;
                        base             <= fetch_base;
                        oMEM_ADDR        <= fetch_base + line_off;
                        oMEM_REQ         <= 1'b1;
                        oBUSY            <= 1'b1;
                        col              <= '0;
                        beat             <= '0;
                        state            <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (iMEM_ACK) begin
                        oMEM_REQ <= 1'b0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (iMEM_VALID) begin
                        col  <= col + 1'b1;
                        beat <= beat + 1'b1;
                        if (beat == BEAT_LAST) begin
                            beat <= '0;
                            if (col == COL_LAST) begin
                                state <= S_DONE;
                            end else begin
                                oMEM_ADDR <= oMEM_ADDR + BURST_A;
                                oMEM_REQ  <= 1'b1;
                                state     <= S_REQ;
                            end
                        end
                    end
                end
                S_DONE: begin
                    valid[fbank] <= 1'b1;
                    oBUSY        <= 1'b0;
                    if (!primed) begin
                        primed   <= 1'b1;
                        nxt_line <= 9'd1;
                        pend     <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // A line change overrides any earlier pending target.
            if (iVADDR != cur_v) begin
                cur_v    <= iVADDR;
                nxt_line <= v_next;
                pend     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DATA && iMEM_VALID)
            buf_ram[fbank][col] <= iMEM_DATA;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            oCOLOR    <= '0;
            oUNDERRUN <= 1'b0;
        end else if (iRD_EN) begin
            if (tp_on) begin
                oCOLOR <= {iHADDR[7:0], iVADDR[7:0], 8'h80};
            end else if (iHADDR >= HPXL_H) begin
                oCOLOR <= '0;
            end else if (!valid[rb] || tag[rb] != iVADDR) begin
                oCOLOR    <= '0;
                oUNDERRUN <= 1'b1;
            end else begin
                oCOLOR <= buf_ram[rb][iHADDR[HW-1:0]];
            end
        end
    end

endmodule
